// File: rtl/di_bus_arbiter_if.sv
// di_bus_arbiter_if: one master's request/grant handshake and register bus toward the arbiter
interface di_bus_arbiter_if #(parameter int DW = 16, parameter int AW = 16);
    logic          req;
    logic          gnt;
    logic [AW-1:0] term_addr;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_datai;
    logic          write;
    logic          read;
    logic          read_req;
    logic [DW-1:0] reg_datao;
    logic          read_rdy;
    logic          write_rdy;
    modport master (
        output req, term_addr, reg_addr, reg_datai, write, read, read_req,
        input  gnt, reg_datao, read_rdy, write_rdy
    );
    modport slave (
        input  req, term_addr, reg_addr, reg_datai, write, read, read_req,
        output gnt, reg_datao, read_rdy, write_rdy
    );
endinterface

// File: rtl/di_bus_arbiter.sv
// di_bus_arbiter: burst-granular round-robin sharing of the di_* terminal bus between two masters
module di_bus_arbiter #(
    parameter int DW = 16,
    parameter int AW = 16
) (
    input  logic                  ifclk,
    input  logic                  reset,
    di_bus_arbiter_if.slave       m0,
    di_bus_arbiter_if.slave       m1,
    output logic [AW-1:0]         di_term_addr,
    output logic [AW-1:0]         di_reg_addr,
    output logic [DW-1:0]         di_reg_datai,
    output logic                  di_write,
    output logic                  di_read,
    output logic                  di_read_req,
    input  logic [DW-1:0]         di_reg_datao,
    input  logic                  di_read_rdy,
    input  logic                  di_write_rdy,
    output logic                  last_owner,
    output logic                  err,
    input  logic                  err_clr
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1, GAP} state_t;
    state_t state, state_n;
    logic own0, own1, held, sel1, blank, viol;
    assign own0 = (state == OWN0);
    assign own1 = (state == OWN1);
    always_ff @(posedge ifclk) begin
        if (reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            held       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state <= state_n;
            if ((own0 && !m0.req) || (own1 && !m1.req)) begin
                last_owner <= own1;
                held       <= 1'b1;
            end
            err <= viol | (err & ~err_clr);
        end
    end
    always_comb begin
        state_n = state;
        state_n = own0 ? (m0.req ? OWN0 : GAP) :
                  own1 ? (m1.req ? OWN1 : GAP) :
                  (state == GAP) ? IDLE :
                  (m0.req && m1.req) ? (last_owner ? OWN0 : OWN1) :
                  m0.req ? OWN0 :
                  m1.req ? OWN1 : IDLE;
    end
    // outside a burst the bus keeps the last owner's values; zero until anyone has owned it
    assign sel1  = own1 | (~own0 & last_owner);
    assign blank = reset | (~own0 & ~own1 & ~held);
    assign di_term_addr = blank ? '0 : sel1 ? m1.term_addr : m0.term_addr;
    assign di_reg_addr  = blank ? '0 : sel1 ? m1.reg_addr  : m0.reg_addr;
    assign di_reg_datai = blank ? '0 : sel1 ? m1.reg_datai : m0.reg_datai;
    assign di_write    = ~reset & ((own0 & m0.write)    | (own1 & m1.write));
    assign di_read     = ~reset & ((own0 & m0.read)     | (own1 & m1.read));
    assign di_read_req = ~reset & ((own0 & m0.read_req) | (own1 & m1.read_req));
    assign viol = (~own0 & (m0.write | m0.read | m0.read_req)) |
                  (~own1 & (m1.write | m1.read | m1.read_req));
    assign m0.gnt       = own0;
    assign m1.gnt       = own1;
    assign m0.read_rdy  = di_read_rdy & own0;
    assign m1.read_rdy  = di_read_rdy & own1;
    assign m0.write_rdy = di_write_rdy & own0;
    assign m1.write_rdy = di_write_rdy & own1;
    assign m0.reg_datao = di_reg_datao;
    assign m1.reg_datao = di_reg_datao;
endmodule

// File: tb/tb_di_bus_arbiter.sv
// tb_di_bus_arbiter: directed plan steps plus random traffic checked against a burst-level model
module tb_di_bus_arbiter;
    localparam int DW = 16;
    localparam int AW = 16;
    logic          ifclk = 1'b0;
    logic          reset, err_clr, err, last_owner;
    logic [AW-1:0] di_term_addr, di_reg_addr;
    logic [DW-1:0] di_reg_datai, di_reg_datao;
    logic          di_write, di_read, di_read_req, di_read_rdy, di_write_rdy;
    int checks = 0;
    int errors = 0;
    di_bus_arbiter_if #(.DW(DW), .AW(AW)) m0_if ();
    di_bus_arbiter_if #(.DW(DW), .AW(AW)) m1_if ();
    di_bus_arbiter #(.DW(DW), .AW(AW)) dut (
        .ifclk(ifclk), .reset(reset), .m0(m0_if), .m1(m1_if),
        .di_term_addr(di_term_addr), .di_reg_addr(di_reg_addr), .di_reg_datai(di_reg_datai),
        .di_write(di_write), .di_read(di_read), .di_read_req(di_read_req),
        .di_reg_datao(di_reg_datao), .di_read_rdy(di_read_rdy), .di_write_rdy(di_write_rdy),
        .last_owner(last_owner), .err(err), .err_clr(err_clr)
    );
    always #5 ifclk = ~ifclk;
    // model: owner -1 = nobody, gap = dead cycle pending, held = last released owner (-1 = none yet)
    int m_owner, m_last, m_held;
    bit m_gap, m_err;
    bit rq[2], wr[2], rd[2], rr[2];
    logic [AW-1:0] ta[2], ra[2];
    logic [DW-1:0] wd[2];
    bit s_rst, s_clr;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask
    task automatic set_m(input int i, input bit q, input bit w, input bit r, input bit x,
                         input logic [AW-1:0] t, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (i == 0) begin
            m0_if.req = q; m0_if.write = w; m0_if.read = r; m0_if.read_req = x;
            m0_if.term_addr = t; m0_if.reg_addr = a; m0_if.reg_datai = d;
        end else begin
            m1_if.req = q; m1_if.write = w; m1_if.read = r; m1_if.read_req = x;
            m1_if.term_addr = t; m1_if.reg_addr = a; m1_if.reg_datai = d;
        end
    endtask
    task automatic snap();
        rq[0] = m0_if.req; wr[0] = m0_if.write; rd[0] = m0_if.read; rr[0] = m0_if.read_req;
        ta[0] = m0_if.term_addr; ra[0] = m0_if.reg_addr; wd[0] = m0_if.reg_datai;
        rq[1] = m1_if.req; wr[1] = m1_if.write; rd[1] = m1_if.read; rr[1] = m1_if.read_req;
        ta[1] = m1_if.term_addr; ra[1] = m1_if.reg_addr; wd[1] = m1_if.reg_datai;
        s_rst = reset; s_clr = err_clr;
    endtask
    task automatic check_all();
        int sel;
        bit blank;
        sel   = (m_owner >= 0) ? m_owner : m_held;
        blank = s_rst || sel < 0;
        if (sel < 0) sel = 0;
        chk("gnt0", m0_if.gnt, m_owner == 0);
        chk("gnt1", m1_if.gnt, m_owner == 1);
        chk("di_write", di_write, !s_rst && m_owner >= 0 && wr[m_owner == 1]);
        chk("di_read", di_read, !s_rst && m_owner >= 0 && rd[m_owner == 1]);
        chk("di_read_req", di_read_req, !s_rst && m_owner >= 0 && rr[m_owner == 1]);
        chk("di_term_addr", di_term_addr, blank ? 0 : ta[sel]);
        chk("di_reg_addr", di_reg_addr, blank ? 0 : ra[sel]);
        chk("di_reg_datai", di_reg_datai, blank ? 0 : wd[sel]);
        chk("rrdy0", m0_if.read_rdy, di_read_rdy && m_owner == 0);
        chk("rrdy1", m1_if.read_rdy, di_read_rdy && m_owner == 1);
        chk("wrdy0", m0_if.write_rdy, di_write_rdy && m_owner == 0);
        chk("wrdy1", m1_if.write_rdy, di_write_rdy && m_owner == 1);
        chk("datao0", m0_if.reg_datao, di_reg_datao);
        chk("datao1", m1_if.reg_datao, di_reg_datao);
        chk("err", err, m_err);
        chk("last_owner", last_owner, m_last);
    endtask
    task automatic update_model();
        bit viol;
        if (s_rst) begin
            m_owner = -1; m_gap = 0; m_last = 1; m_err = 0; m_held = -1;
            return;
        end
        viol = 0;
        for (int i = 0; i < 2; i++)
            if (m_owner != i && (wr[i] || rd[i] || rr[i])) viol = 1;
        m_err = viol || (m_err && !s_clr);
        if (m_owner >= 0) begin
            if (!rq[m_owner]) begin
                m_last = m_owner; m_held = m_owner; m_gap = 1; m_owner = -1;
            end
        end else if (m_gap) m_gap = 0;
        else if (rq[0] && rq[1]) m_owner = 1 - m_last;
        else if (rq[0]) m_owner = 0;
        else if (rq[1]) m_owner = 1;
    endtask
    task automatic cyc();
        #1;
        snap();
        check_all();
        @(posedge ifclk);
        update_model();
        #1;
    endtask
    initial begin
        int seq[$];
        bit pg0, pg1;
        int cnt[2];
        bit q[2];
        m_owner = -1; m_gap = 0; m_last = 1; m_err = 0; m_held = -1;
        reset = 1; err_clr = 0; di_reg_datao = '0; di_read_rdy = 0; di_write_rdy = 0;
        set_m(0, 0, 0, 0, 0, 16'h1111, 16'h2222, 16'h3333);
        set_m(1, 0, 0, 0, 0, 16'h4444, 16'h5555, 16'h6666);
        @(posedge ifclk); #1;
        cyc(); cyc();
        chk("rst_gnt0", m0_if.gnt, 0);
        chk("rst_gnt1", m1_if.gnt, 0);
        chk("rst_last", last_owner, 1);
        chk("rst_err", err, 0);
        chk("rst_addr", di_reg_addr, 0);
        // plan 1
        reset = 0;
        m1_if.req = 1;
        cyc();
        chk("p1_gnt1", m1_if.gnt, 1);
        set_m(1, 1, 1, 0, 0, 16'h0007, 16'h0012, 16'hBEEF);
        #1;
        chk("p1_di_write", di_write, 1);
        chk("p1_addr", di_reg_addr, 16'h0012);
        chk("p1_data", di_reg_datai, 16'hBEEF);
        cyc();
        set_m(1, 0, 0, 0, 0, 16'h0007, 16'h0012, 16'hBEEF);
        cyc(); cyc(); cyc();
        // plan 2
        m0_if.req = 1; m1_if.req = 1;
        cyc();
        chk("p2_gnt0", m0_if.gnt, 1);
        chk("p2_gnt1", m1_if.gnt, 0);
        m0_if.req = 0;
        cyc();
        chk("p2_gap0", m0_if.gnt, 0);
        chk("p2_gap1", m1_if.gnt, 0);
        cyc();
        chk("p2_idle1", m1_if.gnt, 0);
        cyc();
        chk("p2_regrant1", m1_if.gnt, 1);
        m1_if.req = 0;
        cyc(); cyc(); cyc();
        // plan 3
        cnt[0] = 0; cnt[1] = 0; pg0 = 0; pg1 = 0;
        for (int c = 0; c < 80 && seq.size() < 4; c++) begin
            if (m0_if.gnt && !pg0) seq.push_back(0);
            if (m1_if.gnt && !pg1) seq.push_back(1);
            pg0 = m0_if.gnt; pg1 = m1_if.gnt;
            q[0] = 1; q[1] = 1;
            if (m0_if.gnt && ++cnt[0] == 4) begin q[0] = 0; cnt[0] = 0; end
            if (m1_if.gnt && ++cnt[1] == 4) begin q[1] = 0; cnt[1] = 0; end
            set_m(0, q[0], m0_if.gnt && q[0], 0, 0, 16'($urandom), 16'($urandom), 16'($urandom));
            set_m(1, q[1], m1_if.gnt && q[1], 0, 0, 16'($urandom), 16'($urandom), 16'($urandom));
            cyc();
        end
        chk("p3_bursts", seq.size(), 4);
        for (int i = 0; i < seq.size(); i++) chk("p3_order", seq[i], i % 2);
        m0_if.req = 0; m1_if.req = 0; m0_if.write = 0; m1_if.write = 0;
        cyc(); cyc(); cyc(); cyc(); cyc();
        // plan 4
        m0_if.req = 1;
        cyc();
        di_read_rdy = 1; m1_if.read = 1;
        #1;
        chk("p4_di_read", di_read, 0);
        chk("p4_rrdy1", m1_if.read_rdy, 0);
        cyc();
        chk("p4_err_set", err, 1);
        m1_if.read = 0; err_clr = 1;
        cyc();
        chk("p4_err_clr", err, 0);
        m1_if.write = 1;
        cyc();
        chk("p4_set_wins", err, 1);
        m1_if.write = 0;
        cyc();
        err_clr = 0;
        // plan 5
        di_reg_datao = 16'hA5A5;
        #1;
        chk("p5_rrdy0", m0_if.read_rdy, 1);
        chk("p5_rrdy1", m1_if.read_rdy, 0);
        chk("p5_datao0", m0_if.reg_datao, 16'hA5A5);
        chk("p5_datao1", m1_if.reg_datao, 16'hA5A5);
        cyc();
        m0_if.req = 0; di_read_rdy = 0;
        cyc(); cyc(); cyc();
        // plan 6
        m1_if.req = 1;
        cyc();
        m1_if.write = 1;
        cyc();
        reset = 1;
        #1;
        chk("p6_rst_write", di_write, 0);
        cyc();
        chk("p6_rst_gnt1", m1_if.gnt, 0);
        reset = 0; m1_if.write = 0;
        cyc();
        chk("p6_regrant", m1_if.gnt, 1);
        m1_if.req = 0;
        cyc(); cyc(); cyc();
        // random traffic
        q[0] = 0; q[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(7) == 0) q[i] = !q[i];
                set_m(i, q[i], $urandom_range(3) == 0, $urandom_range(5) == 0, $urandom_range(7) == 0,
                      16'($urandom), 16'($urandom), 16'($urandom));
            end
            di_reg_datao = 16'($urandom);
            di_read_rdy = 1'($urandom);
            di_write_rdy = 1'($urandom);
            err_clr = $urandom_range(7) == 0;
            reset = $urandom_range(99) == 0;
            cyc();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
